alias_window_ctrl: RTL and testbench
====================================

Name: alias_window_ctrl

Overview:
- Sequences the pre-LOCK update window for the Harvard-alias write guard.
- Owns the sticky LOCK bit and grants time-bounded `allow_override_prelock` windows to Boot through a req/ack handshake.
- Closes windows on timeout, explicit close or LOCK.
- Counts blocked and overridden D-writes into executable PPNs for telemetry.
- Sits between Boot control CSRs and the alias guard / exec-PPN tracker.

Parameters:
- WIN_CYCLES, 1024: window length in clk cycles, from grant to forced close; must be ≥2.
- MAX_WINDOWS, 4: windows grantable per reset; must be ≥1.
- CNT_W, 16: width of the saturating telemetry counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- lock_req_i  in  1  level; request sticky LOCK
- win_req_i  in  1  request an override window; held until ack or nack
- win_close_i  in  1  close the open window early
- write_valid_i  in  1  D-side write valid, observed at guard input
- write_en_i  in  1  D-side write enable
- hit_exec_ppn_i  in  1  tracker hit for the current write address
- lock_o  out  1  sticky LOCK to guard and tracker
- allow_override_prelock_o  out  1  override enable to guard
- win_ack_o  out  1  one-cycle pulse; window granted
- win_nack_o  out  1  one-cycle pulse; request refused
- win_timeout_o  out  1  one-cycle pulse; window closed by timer
- win_used_o  out  $clog2(MAX_WINDOWS+1)  windows granted since reset
- blocked_cnt_o  out  CNT_W  exec-PPN writes denied
- override_cnt_o  out  CNT_W  exec-PPN writes permitted via override

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, state IDLE, timer 0.
- Reset mid-window drops the override the next cycle.
- FSM states: IDLE, OPEN, COOLDOWN, LOCKED.
- IDLE:
  - lock_req_i → LOCKED.
  - Else win_req_i with win_used_o<MAX_WINDOWS → OPEN. Pulse win_ack_o, increment win_used_o, load timer with WIN_CYCLES-1.
  - Else win_req_i with budget exhausted → pulse win_nack_o, stay IDLE.
- OPEN:
  - allow_override_prelock_o=1, registered, asserted the cycle after the ack.
  - Timer decrements each cycle.
  - Priority: lock_req_i > win_close_i > timer==0.
  - lock_req_i → LOCKED; override drops the same edge lock_o rises.
  - win_close_i → COOLDOWN.
  - timer==0 → COOLDOWN plus win_timeout_o pulse.
  - win_req_i is ignored in OPEN (no ack, no nack).
- COOLDOWN:
  - Override 0 for exactly 2 cycles so in-flight writes see the guard closed; then IDLE.
  - lock_req_i during COOLDOWN → LOCKED.
  - win_req_i is held off, not nacked.
- LOCKED:
  - Terminal until reset; lock_o=1, override 0.
  - Every win_req_i cycle pulses win_nack_o.
- The override path must satisfy: lock_o=1 implies allow_override_prelock_o=0, every cycle.
- Telemetry: exec write = write_valid_i & write_en_i & hit_exec_ppn_i.
  - Exec write with override=1 and lock_o=0 → override_cnt_o+1.
  - Any other exec write → blocked_cnt_o+1.
  - Both counters saturate at 2^CNT_W-1.
  - Counters run in every state, including LOCKED.
- win_used_o saturates at MAX_WINDOWS and never wraps.
- Timer width is $clog2(WIN_CYCLES).

Optional Feature:
- Macro: ALIAS_WIN_AUTOLOCK_EN.
- Defined: when the final window (win_used_o==MAX_WINDOWS) closes by any cause, the FSM goes COOLDOWN → LOCKED instead of IDLE; lock_o rises 2 cycles after the close.
- Undefined: FSM returns to IDLE and later requests are nacked; LOCK only via lock_req_i.

Decomposition:
- Package harvos_guard_pkg holds:
  - the 2-bit FSM state enum win_state_e;
  - the constant COOLDOWN_CYCLES=2;
  - the function for the exec-write predicate.
- One sub-module, sat_counter (parameter W; inc, clear, q), instantiated twice for the telemetry counters.
- The timer stays inline.

Test Plan:
- Reset, then win_req_i=1 → win_ack_o pulse at cycle 1; override=1 from cycle 2 to 1025 with WIN_CYCLES=1024; win_timeout_o pulse; override 0; IDLE after 2 cooldown cycles.
- Grant 4 windows, closing each via win_close_i; 5th request → win_nack_o; win_used_o=4; override never re-asserts.
- lock_req_i while OPEN at timer=500 → lock_o=1 and override=0 on the same edge; later win_req_i → nack each cycle; only rst_n=0 clears lock_o.
- 3 exec writes in OPEN, 2 in IDLE, 1 non-exec write → override_cnt_o=3, blocked_cnt_o=2; with CNT_W=4, 20 blocked writes saturate at 15.
- lock_req_i, win_close_i and timer expiry in the same cycle → LOCKED wins; no win_timeout_o pulse.
- With ALIAS_WIN_AUTOLOCK_EN and MAX_WINDOWS=1: grant, close → lock_o=1 exactly 2 cycles later. Without the macro: lock_o stays 0.

Source files
------------

// File: rtl/harvos_guard_pkg.sv
// rtl/harvos_guard_pkg.sv - shared types and helpers for the Harvard-alias write guard
package harvos_guard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OPEN     = 2'd1,
    ST_COOLDOWN = 2'd2,
    ST_LOCKED   = 2'd3
  } win_state_e;

  localparam int COOLDOWN_CYCLES = 2;

  function automatic logic is_exec_write(input logic valid, input logic en, input logic hit);
    return valid & en & hit;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/alias_window_ctrl.sv
// rtl/alias_window_ctrl.sv - pre-LOCK override window sequencer and exec-write telemetry
// Optional: ALIAS_WIN_AUTOLOCK_EN locks automatically after the final window's cooldown.
module alias_window_ctrl
  import harvos_guard_pkg::*;
#(
  parameter int WIN_CYCLES  = 1024,
  parameter int MAX_WINDOWS = 4,
  parameter int CNT_W       = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             lock_req_i,
  input  logic                             win_req_i,
  input  logic                             win_close_i,
  input  logic                             write_valid_i,
  input  logic                             write_en_i,
  input  logic                             hit_exec_ppn_i,
  output logic                             lock_o,
  output logic                             allow_override_prelock_o,
  output logic                             win_ack_o,
  output logic                             win_nack_o,
  output logic                             win_timeout_o,
  output logic [$clog2(MAX_WINDOWS+1)-1:0] win_used_o,
  output logic [CNT_W-1:0]                 blocked_cnt_o,
  output logic [CNT_W-1:0]                 override_cnt_o
);

  localparam int TW = $clog2(WIN_CYCLES);
  localparam int UW = $clog2(MAX_WINDOWS + 1);
  localparam logic [UW-1:0] MAX_W = UW'(MAX_WINDOWS);

  win_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [UW-1:0] used_q, used_d;
  logic          lock_q, lock_d;
  logic          override_q, override_d;
  logic          ack_q, ack_d;
  logic          nack_q, nack_d;
  logic          timeout_q, timeout_d;
  logic          exec_wr, ovr_inc, blk_inc;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    used_d    = used_q;
    ack_d     = 1'b0;
    nack_d    = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lock_req_i) begin
          state_d = ST_LOCKED;
        end else if (win_req_i) begin
          if (used_q < MAX_W) begin
            state_d = ST_OPEN;
            ack_d   = 1'b1;
            used_d  = used_q + UW'(1);
            timer_d = TW'(WIN_CYCLES - 1);
          end else begin
            nack_d = 1'b1;
          end
        end
      end
      ST_OPEN: begin
        timer_d = timer_q - TW'(1);
        if (lock_req_i) begin
          state_d = ST_LOCKED;
        end else if (win_close_i) begin
          state_d = ST_COOLDOWN;
          timer_d = TW'(COOLDOWN_CYCLES - 1);
        end else if (timer_q == '0) begin
          state_d   = ST_COOLDOWN;
          timeout_d = 1'b1;
          timer_d   = TW'(COOLDOWN_CYCLES - 1);
        end
      end
      ST_COOLDOWN: begin
        // The timer is reused to hold the guard closed while in-flight writes drain.
        if (lock_req_i) begin
          state_d = ST_LOCKED;
        end else if (timer_q == '0) begin
`ifdef ALIAS_WIN_AUTOLOCK_EN
          state_d = (used_q == MAX_W) ? ST_LOCKED : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_LOCKED: begin
        nack_d = win_req_i;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Override only while staying OPEN, so it falls on the same edge LOCK rises.
    override_d = (state_q == ST_OPEN) && (state_d == ST_OPEN);
    lock_d     = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      used_q     <= '0;
      lock_q     <= 1'b0;
      override_q <= 1'b0;
      ack_q      <= 1'b0;
      nack_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      used_q     <= used_d;
      lock_q     <= lock_d;
      override_q <= override_d;
      ack_q      <= ack_d;
      nack_q     <= nack_d;
      timeout_q  <= timeout_d;
    end
  end

  assign exec_wr = is_exec_write(write_valid_i, write_en_i, hit_exec_ppn_i);
  assign ovr_inc = exec_wr & override_q & ~lock_q;
  assign blk_inc = exec_wr & ~ovr_inc;

  sat_counter #(.W(CNT_W)) u_blocked_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .inc   (blk_inc),
    .q     (blocked_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_override_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .inc   (ovr_inc),
    .q     (override_cnt_o)
  );

  assign lock_o                   = lock_q;
  assign allow_override_prelock_o = override_q;
  assign win_ack_o                = ack_q;
  assign win_nack_o               = nack_q;
  assign win_timeout_o            = timeout_q;
  assign win_used_o               = used_q;

endmodule

// File: tb/tb_alias_window_ctrl.sv
// tb/tb_alias_window_ctrl.sv - directed self-checking bench for alias_window_ctrl
module tb_alias_window_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, lock_req_i, win_req_i, win_close_i;
  logic       write_valid_i, write_en_i, hit_exec_ppn_i;
  logic       lock_o, allow_override_prelock_o, win_ack_o, win_nack_o, win_timeout_o;
  logic [2:0] win_used_o;
  logic [3:0] blocked_cnt_o, override_cnt_o;

  int compared = 0;
  int mismatched = 0;

  alias_window_ctrl #(.WIN_CYCLES(1024), .MAX_WINDOWS(4), .CNT_W(4)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .lock_req_i               (lock_req_i),
    .win_req_i                (win_req_i),
    .win_close_i              (win_close_i),
    .write_valid_i            (write_valid_i),
    .write_en_i               (write_en_i),
    .hit_exec_ppn_i           (hit_exec_ppn_i),
    .lock_o                   (lock_o),
    .allow_override_prelock_o (allow_override_prelock_o),
    .win_ack_o                (win_ack_o),
    .win_nack_o               (win_nack_o),
    .win_timeout_o            (win_timeout_o),
    .win_used_o               (win_used_o),
    .blocked_cnt_o            (blocked_cnt_o),
    .override_cnt_o           (override_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_wr(input logic v, input logic e, input logic h);
    write_valid_i  = v;
    write_en_i     = e;
    hit_exec_ppn_i = h;
  endtask

  initial begin
    rst_n = 1'b0; lock_req_i = 1'b0; win_req_i = 1'b0; win_close_i = 1'b0;
    set_wr(1'b0, 1'b0, 1'b0);
    tick(2);
    chk("rst_lock", lock_o, 0);
    chk("rst_ovr", allow_override_prelock_o, 0);
    chk("rst_ack", win_ack_o, 0);
    chk("rst_nack", win_nack_o, 0);
    chk("rst_tmo", win_timeout_o, 0);
    chk("rst_used", win_used_o, 0);
    chk("rst_blk", blocked_cnt_o, 0);
    chk("rst_ocnt", override_cnt_o, 0);
    rst_n = 1'b1;

    // Window 1 runs to timeout: grant at edge 1, override edges 2..1024, close at 1025.
    win_req_i = 1'b1;
    tick(1);
    chk("w1_ack", win_ack_o, 1);
    chk("w1_ovr_c1", allow_override_prelock_o, 0);
    chk("w1_used", win_used_o, 1);
    win_req_i = 1'b0;
    tick(1);
    chk("w1_ovr_c2", allow_override_prelock_o, 1);
    chk("w1_ack_c2", win_ack_o, 0);
    tick(1022);
    chk("w1_ovr_c1024", allow_override_prelock_o, 1);
    chk("w1_tmo_c1024", win_timeout_o, 0);
    tick(1);
    chk("w1_ovr_c1025", allow_override_prelock_o, 0);
    chk("w1_tmo_c1025", win_timeout_o, 1);
    win_req_i = 1'b1;
    tick(1);
    chk("cd_tmo_gone", win_timeout_o, 0);
    chk("cd1_ack", win_ack_o, 0);
    chk("cd1_nack", win_nack_o, 0);
    tick(1);
    chk("cd2_ack", win_ack_o, 0);
    chk("cd2_nack", win_nack_o, 0);
    tick(1);
    chk("w2_ack", win_ack_o, 1);
    chk("w2_used", win_used_o, 2);
    win_req_i = 1'b0;
    tick(1);
    chk("w2_ovr", allow_override_prelock_o, 1);

    // Telemetry: 3 exec writes under override, 1 non-exec, then 2 exec in IDLE.
    set_wr(1'b1, 1'b1, 1'b1);
    tick(3);
    chk("tel_ocnt3", override_cnt_o, 3);
    chk("tel_blk0", blocked_cnt_o, 0);
    set_wr(1'b1, 1'b1, 1'b0);
    tick(1);
    chk("tel_nonexec", override_cnt_o, 3);
    set_wr(1'b0, 1'b0, 1'b0);
    win_close_i = 1'b1;
    tick(1);
    chk("w2_close_ovr", allow_override_prelock_o, 0);
    chk("w2_close_tmo", win_timeout_o, 0);
    win_close_i = 1'b0;
    tick(2);
    set_wr(1'b1, 1'b1, 1'b1);
    tick(2);
    chk("tel_blk2", blocked_cnt_o, 2);
    chk("tel_ocnt_hold", override_cnt_o, 3);
    set_wr(1'b0, 1'b0, 1'b0);

    // Window 3 then window 4, each closed early.
    win_req_i = 1'b1;
    tick(1);
    chk("w3_ack", win_ack_o, 1);
    chk("w3_used", win_used_o, 3);
    win_req_i = 1'b0;
    tick(1);
    win_close_i = 1'b1;
    tick(1);
    win_close_i = 1'b0;
    tick(2);
    win_req_i = 1'b1;
    tick(1);
    chk("w4_ack", win_ack_o, 1);
    chk("w4_used", win_used_o, 4);
    win_req_i = 1'b0;
    tick(1);
    win_close_i = 1'b1;
    tick(1);
    win_close_i = 1'b0;
    chk("w4_close_ovr", allow_override_prelock_o, 0);
    tick(1);
    chk("w4_lock_c1", lock_o, 0);
    tick(1);
`ifdef ALIAS_WIN_AUTOLOCK_EN
    chk("w4_autolock", lock_o, 1);
`else
    chk("w4_nolock", lock_o, 0);
`endif
    win_req_i = 1'b1;
    tick(1);
    chk("w5_nack", win_nack_o, 1);
    chk("w5_ack", win_ack_o, 0);
    chk("w5_ovr", allow_override_prelock_o, 0);
    chk("w5_used", win_used_o, 4);
    tick(1);
    chk("w5_nack2", win_nack_o, 1);
    chk("w5_ovr2", allow_override_prelock_o, 0);
    win_req_i = 1'b0;

    // LOCK at timer=500 (cycle 524 after the grant edge).
    rst_n = 1'b0;
    tick(1);
    chk("rst2_used", win_used_o, 0);
    chk("rst2_ocnt", override_cnt_o, 0);
    chk("rst2_lock", lock_o, 0);
    rst_n = 1'b1;
    win_req_i = 1'b1;
    tick(1);
    chk("l_ack", win_ack_o, 1);
    win_req_i = 1'b0;
    tick(523);
    chk("l_ovr_pre", allow_override_prelock_o, 1);
    lock_req_i = 1'b1;
    tick(1);
    lock_req_i = 1'b0;
    chk("l_lock", lock_o, 1);
    chk("l_ovr", allow_override_prelock_o, 0);
    chk("l_tmo", win_timeout_o, 0);
    win_req_i = 1'b1;
    tick(1);
    chk("l_nack1", win_nack_o, 1);
    chk("l_ack1", win_ack_o, 0);
    tick(1);
    chk("l_nack2", win_nack_o, 1);
    win_req_i = 1'b0;
    tick(1);
    chk("l_nack_off", win_nack_o, 0);
    chk("l_sticky", lock_o, 1);
    set_wr(1'b1, 1'b1, 1'b1);
    tick(20);
    chk("sat_blk15", blocked_cnt_o, 15);
    chk("sat_ocnt0", override_cnt_o, 0);
    set_wr(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick(1);
    chk("rst3_lock", lock_o, 0);
    chk("rst3_blk", blocked_cnt_o, 0);
    rst_n = 1'b1;

    // lock_req, win_close and timer==0 together: LOCKED wins, no timeout pulse.
    win_req_i = 1'b1;
    tick(1);
    win_req_i = 1'b0;
    tick(1023);
    chk("col_ovr_pre", allow_override_prelock_o, 1);
    lock_req_i  = 1'b1;
    win_close_i = 1'b1;
    tick(1);
    lock_req_i  = 1'b0;
    win_close_i = 1'b0;
    chk("col_lock", lock_o, 1);
    chk("col_ovr", allow_override_prelock_o, 0);
    chk("col_tmo", win_timeout_o, 0);

    // Reset mid-window drops the override on the next edge.
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    win_req_i = 1'b1;
    tick(1);
    win_req_i = 1'b0;
    tick(1);
    chk("mid_ovr_on", allow_override_prelock_o, 1);
    rst_n = 1'b0;
    tick(1);
    chk("mid_rst_ovr", allow_override_prelock_o, 0);
    chk("mid_rst_used", win_used_o, 0);
    rst_n = 1'b1;
    tick(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
